// File: rtl/sd_cmd_phys_if.sv
// Controller <-> CMD-line phys request/response bundle.
// Handshake: the controller raises strobe_in with cmd_to_send stable; the phys raises
// strobe_out with response/timeout_out stable until ack_in; the phys then holds ack_out
// until strobe_in drops (four-phase, both sides return to zero before the next request).
interface sd_cmd_phys_if #(
    parameter int RESP_LEN = 48
);
    logic                strobe_in;
    logic                ack_in;
    logic                idle_in;
    logic [39:0]         cmd_to_send;
    logic                TIMEOUT_ENABLE;
    logic                strobe_out;
    logic                ack_out;
    logic [RESP_LEN-1:0] response;
    logic                timeout_out;

    modport master (
        output strobe_in, ack_in, idle_in, cmd_to_send, TIMEOUT_ENABLE,
        input  strobe_out, ack_out, response, timeout_out
    );

    modport slave (
        input  strobe_in, ack_in, idle_in, cmd_to_send, TIMEOUT_ENABLE,
        output strobe_out, ack_out, response, timeout_out
    );
endinterface

// File: rtl/sd_cmd_phys.sv
// SD CMD-line physical layer: frames a 40-bit command with CRC7, shifts it out on the
// bidirectional pin, captures the card response and hands it back via strobe/ack.
module sd_cmd_phys #(
    parameter int RESP_LEN       = 48,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           sd_clock,
    input  logic           reset,
    sd_cmd_phys_if.slave   bus,
    inout  wire            cmd_pin,
    output logic [2:0]     state_dbg,
    output logic           cmd_oe_dbg
);
    localparam int CNT_W = $clog2((RESP_LEN > 48) ? RESP_LEN : 48);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_RESP = 3'd2,
        RECEIVE   = 3'd3,
        SEND_BACK = 3'd4,
        WAIT_ACK  = 3'd5
    } state_t;

    state_t              state;
    logic [47:0]         shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                cmd_oe;
    logic                cmd_do;
    logic                strobe_q;
    logic [RESP_LEN-1:0] response_r;
    logic                strobe_out_r;
    logic                ack_out_r;
    logic                timeout_r;
    logic [47:0]         frame;

    // CRC7, x^7 + x^3 + 1, zero seed, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    always_comb begin
        frame = {2'b01, bus.cmd_to_send[37:0], crc7({2'b01, bus.cmd_to_send[37:0]}), 1'b1};
    end

    assign cmd_pin         = cmd_oe ? cmd_do : 1'bz;
    assign state_dbg       = state;
    assign cmd_oe_dbg      = cmd_oe;
    assign bus.strobe_out  = strobe_out_r;
    assign bus.ack_out     = ack_out_r;
    assign bus.response    = response_r;
    assign bus.timeout_out = timeout_r;

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            cmd_oe       <= 1'b0;
            cmd_do       <= 1'b0;
            strobe_q     <= 1'b0;
            response_r   <= '0;
            strobe_out_r <= 1'b0;
            ack_out_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            strobe_q <= bus.strobe_in;
            if (bus.idle_in) begin
                state        <= IDLE;
                cmd_oe       <= 1'b0;
                bit_cnt      <= '0;
                to_cnt       <= '0;
                strobe_out_r <= 1'b0;
                ack_out_r    <= 1'b0;
                timeout_r    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Rising edge only, so a strobe left high after an abort cannot restart.
                        if (bus.strobe_in && !strobe_q) begin
                            cmd_oe  <= 1'b1;
                            cmd_do  <= frame[47];
                            shreg   <= {frame[46:0], 1'b0};
                            bit_cnt <= '0;
                            state   <= SEND;
                        end
                    end
                    SEND: begin
                        if (bit_cnt == CNT_W'(47)) begin
                            cmd_oe  <= 1'b0;
                            to_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= WAIT_RESP;
                        end else begin
                            cmd_do  <= shreg[47];
                            shreg   <= {shreg[46:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    WAIT_RESP: begin
                        if (cmd_pin == 1'b0) begin
                            // Start bit enters at LSB and reaches MSB after the remaining shifts.
                            response_r <= {response_r[RESP_LEN-2:0], 1'b0};
                            bit_cnt    <= '0;
                            state      <= RECEIVE;
                        end else if (bus.TIMEOUT_ENABLE) begin
                            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                                timeout_r    <= 1'b1;
                                strobe_out_r <= 1'b1;
                                state        <= SEND_BACK;
                            end else begin
                                to_cnt <= to_cnt + 1'b1;
                            end
                        end
                    end
                    RECEIVE: begin
                        response_r <= {response_r[RESP_LEN-2:0], cmd_pin};
                        if (bit_cnt == CNT_W'(RESP_LEN - 2)) begin
                            bit_cnt      <= '0;
                            strobe_out_r <= 1'b1;
                            state        <= SEND_BACK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    SEND_BACK: begin
                        if (bus.ack_in) begin
                            strobe_out_r <= 1'b0;
                            ack_out_r    <= 1'b1;
                            state        <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (!bus.strobe_in) begin
                            ack_out_r <= 1'b0;
                            timeout_r <= 1'b0;
                            to_cnt    <= '0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_cmd_phys.sv
// Directed bench for sd_cmd_phys: frame bits and responses are predicted into queues
// and compared when the pin / strobe_out produce them.
module tb_sd_cmd_phys;
  localparam int RESP_LEN = 48;
  localparam logic [2:0] S_IDLE = 3'd0, S_SEND = 3'd1, S_WAIT = 3'd2,
                         S_RECV = 3'd3, S_BACK = 3'd4, S_WACK = 3'd5;

  logic sd_clock;
  logic reset;
  wire  cmd_pin;
  logic [2:0] state_dbg;
  logic cmd_oe_dbg;
  logic card_bit;

  int checks;
  int failures;

  logic [0:0]          exp_q[$];
  logic [RESP_LEN-1:0] resp_q[$];

  logic [47:0] reply;
  logic [39:0] cmd;

  sd_cmd_phys_if #(.RESP_LEN(RESP_LEN)) bus ();

  sd_cmd_phys #(.RESP_LEN(RESP_LEN), .TIMEOUT_CYCLES(64)) dut (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .bus        (bus),
    .cmd_pin    (cmd_pin),
    .state_dbg  (state_dbg),
    .cmd_oe_dbg (cmd_oe_dbg)
  );

  // Card side: drives the line whenever the phys has released it; idles high.
  assign cmd_pin = cmd_oe_dbg ? 1'bz : card_bit;

  // clock / reset
  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CRC7 as remainder of (message * x^7) mod (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [39:0] c);
    return {2'b01, c[37:0], crc7_model({2'b01, c[37:0]}), 1'b1};
  endfunction

  // driver: request a frame and check every bit leaving the pin
  task automatic run_frame(input logic [39:0] c, input logic [47:0] f,
                           input bit hold, input int abort_at);
    @(negedge sd_clock);
    for (int i = 47; i >= 0; i--) exp_q.push_back(f[i]);
    bus.cmd_to_send = c;
    bus.strobe_in   = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge sd_clock);
      if (!hold) bus.strobe_in = 1'b0;
      chk("pin_oe_send", cmd_oe_dbg, 1);
      chk($sformatf("pin_bit_%0d", 47 - i), cmd_pin, exp_q.pop_front());
      if (i == abort_at) begin
        bus.idle_in = 1'b1;
        @(negedge sd_clock);
        bus.idle_in = 1'b0;
        chk("abort_oe", cmd_oe_dbg, 0);
        chk("abort_state", state_dbg, S_IDLE);
        chk("abort_strobe", bus.strobe_out, 0);
        chk("abort_ack", bus.ack_out, 0);
        chk("abort_timeout", bus.timeout_out, 0);
        exp_q.delete();
        return;
      end
    end
    @(negedge sd_clock);
    chk("pin_released", cmd_oe_dbg, 0);
    chk("state_wait_resp", state_dbg, S_WAIT);
  endtask

  task automatic abort_now();
    @(negedge sd_clock);
    bus.idle_in = 1'b1;
    @(negedge sd_clock);
    bus.idle_in = 1'b0;
    chk("idle_state", state_dbg, S_IDLE);
    chk("idle_oe", cmd_oe_dbg, 0);
  endtask

  task automatic wait_strobe(input int budget);
    for (int k = 0; k < budget && bus.strobe_out !== 1'b1; k++) @(negedge sd_clock);
    chk("strobe_out_seen", bus.strobe_out, 1);
  endtask

  task automatic card_send(input logic [47:0] r, input int nbits);
    for (int i = 47; i >= 48 - nbits; i--) begin
      card_bit = r[i];
      @(negedge sd_clock);
    end
    card_bit = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    card_bit = 1'b1;
    bus.strobe_in      = 1'b0;
    bus.ack_in         = 1'b0;
    bus.idle_in        = 1'b0;
    bus.cmd_to_send    = '0;
    bus.TIMEOUT_ENABLE = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_oe", cmd_oe_dbg, 0);
    chk("rst_strobe", bus.strobe_out, 0);
    chk("rst_ack", bus.ack_out, 0);
    chk("rst_timeout", bus.timeout_out, 0);
    chk("rst_response", bus.response, 0);

    // CMD0: known frame 0x40_0000_0000_95 (CRC 0x4A)
    run_frame(40'h0, 48'h40_0000_0000_95, 1'b0, -1);
    abort_now();

    // CMD7, card replies after 10 cycles, full four-phase handshake
    reply = 48'h07_0000_0900_01;
    cmd   = {2'b00, 6'd7, 32'h0};
    run_frame(cmd, make_frame(cmd), 1'b1, -1);
    repeat (10) @(negedge sd_clock);
    resp_q.push_back(reply);
    card_send(reply, 48);
    wait_strobe(8);
    chk("resp_value", bus.response, resp_q.pop_front());
    chk("resp_no_timeout", bus.timeout_out, 0);
    chk("resp_state", state_dbg, S_BACK);
    bus.ack_in = 1'b1;
    @(negedge sd_clock);
    bus.ack_in = 1'b0;
    chk("ack_out_set", bus.ack_out, 1);
    chk("ack_strobe_clr", bus.strobe_out, 0);
    repeat (3) @(negedge sd_clock);
    chk("ack_held_while_strobe", bus.ack_out, 1);
    chk("wait_ack_state", state_dbg, S_WACK);
    bus.strobe_in = 1'b0;
    @(negedge sd_clock);
    chk("ack_out_clr", bus.ack_out, 0);
    chk("back_to_idle", state_dbg, S_IDLE);

    // Timeout enabled, line held high: exactly 64 cycles in WAIT_RESP
    bus.TIMEOUT_ENABLE = 1'b1;
    cmd = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
    run_frame(cmd, make_frame(cmd), 1'b0, -1);
    repeat (63) @(negedge sd_clock);
    chk("timeout_not_early", bus.strobe_out, 0);
    @(negedge sd_clock);
    chk("timeout_strobe", bus.strobe_out, 1);
    chk("timeout_flag", bus.timeout_out, 1);
    chk("timeout_resp_kept", bus.response, reply);
    bus.ack_in = 1'b1;
    @(negedge sd_clock);
    bus.ack_in = 1'b0;
    chk("timeout_ack", bus.ack_out, 1);
    @(negedge sd_clock);
    chk("timeout_cleared", bus.timeout_out, 0);
    chk("timeout_idle", state_dbg, S_IDLE);

    // Timeout disabled: no reply for 7000 ns keeps waiting
    bus.TIMEOUT_ENABLE = 1'b0;
    cmd = {2'b11, 6'd17, 32'($urandom)};
    run_frame(cmd, make_frame(cmd), 1'b0, -1);
    repeat (700) @(negedge sd_clock);
    chk("nto_state", state_dbg, S_WAIT);
    chk("nto_strobe", bus.strobe_out, 0);
    chk("nto_oe", cmd_oe_dbg, 0);
    abort_now();
    chk("nto_resp_kept", bus.response, reply);

    // idle_in during SEND bit 20, then a fresh frame
    cmd = {2'b00, 6'd55, 32'($urandom)};
    run_frame(cmd, make_frame(cmd), 1'b0, 20);
    cmd = {2'b00, 6'd8, 32'h0000_01AA};
    run_frame(cmd, make_frame(cmd), 1'b0, -1);
    abort_now();

    // Async reset mid-RECEIVE, then a complete new frame
    cmd = {2'b00, 6'd2, 32'h0};
    run_frame(cmd, make_frame(cmd), 1'b0, -1);
    repeat (2) @(negedge sd_clock);
    card_send(48'h3F_1234_5678_9B, 20);
    card_bit = 1'b0;
    chk("recv_state", state_dbg, S_RECV);
    #2 reset = 1'b1;
    #1;
    chk("arst_oe", cmd_oe_dbg, 0);
    chk("arst_state", state_dbg, S_IDLE);
    chk("arst_response", bus.response, 0);
    chk("arst_strobe", bus.strobe_out, 0);
    card_bit = 1'b1;
    @(negedge sd_clock);
    reset = 1'b0;
    cmd = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
    run_frame(cmd, make_frame(cmd), 1'b0, -1);
    abort_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_cmd_phys.md
Name: sd_cmd_phys

Overview:
SD-card CMD-line physical layer, clocked by the card clock. It takes a 40-bit command from the host-side CMD controller and builds the 48-bit frame with CRC7 and end bit. It shifts the frame out MSB-first on the bidirectional CMD pin, then releases the pin and captures the card response. The response is handed back to the controller through a strobe/ack handshake, with an optional response timeout.

Parameters:
RESP_LEN, 48, response length in bits, start bit included (136 for long responses).
TIMEOUT_CYCLES, 64, sd_clock cycles to wait for the response start bit when timeout is enabled.

Ports:
sd_clock  input  1  card clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
strobe_in  input  1  controller request: cmd_to_send is valid, start a transaction.
ack_in  input  1  controller acknowledges response (response consumed).
idle_in  input  1  synchronous abort; forces IDLE and releases the pin.
cmd_to_send  input  40  [39:38] ignored, [37:32] command index, [31:0] argument.
TIMEOUT_ENABLE  input  1  1 = apply TIMEOUT_CYCLES limit; 0 = wait indefinitely.
cmd_pin  inout  1  SD CMD line; driven only while sending, otherwise high-Z.
strobe_out  output  1  response (or timeout) ready for the controller.
ack_out  output  1  phys acknowledges strobe_in after the transaction completes.
response  output  RESP_LEN  captured response bits, first received bit at MSB.
timeout_out  output  1  set with strobe_out when no start bit arrived in time.

Behaviour:
- Reset (async) values:
  - state IDLE.
  - cmd_pin high-Z.
  - strobe_out=0, ack_out=0, timeout_out=0, response=0.
  - all counters 0.
- Frame construction: frame[47:0] = {1'b0, 1'b1, cmd_to_send[37:0], crc7, 1'b1}.
  - crc7 uses polynomial x^7+x^3+1, initial value 0, computed over frame[47:8].
  - The frame is latched when strobe_in is sampled high in IDLE.
- States: IDLE, SEND, WAIT_RESP, RECEIVE, SEND_BACK, WAIT_ACK.
- IDLE:
  - On strobe_in=1, latch the frame and go to SEND.
  - The frame MSB (start bit 0) appears on cmd_pin the cycle after strobe_in is sampled.
- SEND:
  - One bit per cycle, MSB first, 48 cycles.
  - After the end bit, release the pin (high-Z) and go to WAIT_RESP.
- WAIT_RESP:
  - Sample cmd_pin each cycle; the first 0 is the response start bit. Store it at response MSB and go to RECEIVE.
  - If TIMEOUT_ENABLE=1 and TIMEOUT_CYCLES cycles pass with no 0 sampled: timeout_out=1, response unchanged, go to SEND_BACK.
  - If TIMEOUT_ENABLE=0, wait indefinitely.
- RECEIVE:
  - Shift in RESP_LEN-1 further bits, MSB first, one per cycle.
  - Then go to SEND_BACK; response is fully valid on entry.
- SEND_BACK:
  - strobe_out=1; hold response and timeout_out stable.
  - When ack_in is sampled high: strobe_out=0, ack_out=1, go to WAIT_ACK.
- WAIT_ACK:
  - Hold ack_out=1 until strobe_in is sampled low.
  - Then ack_out=0, timeout_out=0, go to IDLE.
  - This completes a four-phase handshake.
- Boundary and simultaneous events:
  - strobe_in held high across a completed transaction never restarts it; a new strobe_in rising is required after returning to IDLE.
  - idle_in=1 in any state: next cycle go to IDLE, pin high-Z, strobe_out=ack_out=timeout_out=0, response retained. idle_in has priority over all other inputs.
  - reset mid-frame: pin high-Z immediately (async), full reset values.
  - ack_in while not in SEND_BACK is ignored.
- The pin pad is internal: output enable and output data registered, input sampled on sd_clock.

Test Plan:
- Reset, then cmd_to_send={2'b0, 6'd0, 32'h0}, strobe_in pulse -> cmd_pin sequence 0,1,000000, 32×0, CRC 1001010 (0x4A), 1 over 48 cycles, then high-Z.
- Index 7, arg 0, TIMEOUT_ENABLE=0, card model replies after 10 cycles with 48-bit 0x07_0000_0900_01 -> strobe_out=1, response equals the reply; ack_in -> ack_out=1; strobe_in low -> IDLE.
- TIMEOUT_ENABLE=1, pin pulled high (no reply) -> after 64 cycles in WAIT_RESP: strobe_out=1, timeout_out=1.
- TIMEOUT_ENABLE=0, no reply for 7000 ns -> remains in WAIT_RESP; strobe_out stays 0, pin high-Z.
- idle_in=1 during SEND bit 20 -> pin high-Z next cycle, all handshake outputs 0; subsequent strobe_in starts a fresh frame.
- Async reset asserted during RECEIVE -> outputs immediately at reset values; strobe_in after release sends a complete new frame.
